// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8N1 byte receiver feeding a framed command parser
// (A5 | cmd | payload | xor-checksum) that drives WBL, address and IO controls.
// Ports: clk_100m/rst_n; uart_rxd serial in; rx_byte_valid/rx_byte per good byte;
//   wbl_we/wbl_chip/wbl_data, addr_we/wwl_add/rwl_add/demux_add, io_start/io_model
//   update only on accepted frames; cmd_ok/cmd_err pulse once per frame outcome.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 16
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        uart_rxd,
  output logic        rx_byte_valid,
  output logic [7:0]  rx_byte,
  output logic        wbl_we,
  output logic [3:0]  wbl_chip,
  output logic [63:0] wbl_data,
  output logic        addr_we,
  output logic [5:0]  wwl_add,
  output logic [5:0]  rwl_add,
  output logic [1:0]  demux_add,
  output logic        io_start,
  output logic [1:0]  io_model,
  output logic        cmd_ok,
  output logic        cmd_err
);
  localparam int CW        = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF      = CLKS_PER_BIT / 2;
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);

  // ---------------- input synchroniser ----------------
  logic rxd_meta, rxd_s, rxd_prev;
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  // ---------------- byte receiver ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
  rx_state_t rx_state, rx_next;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_tick, half_tick, stop_ok, stop_bad, frame_err;

  assign bit_tick  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign half_tick = (clk_cnt == CW'(HALF - 1));

  always_comb begin
    rx_next  = rx_state;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (rx_state)
      R_IDLE:  if (rxd_prev && !rxd_s) rx_next = R_START;
      // a start bit that is high again at mid-bit was only a glitch
      R_START: if (half_tick) rx_next = rxd_s ? R_IDLE : R_DATA;
      R_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = R_STOP;
      R_STOP: begin
        if (bit_tick) begin
          if (rxd_s) begin
            rx_next = R_IDLE;
            stop_ok = 1'b1;
          end else begin
            rx_next  = R_WAIT;
            stop_bad = 1'b1;
          end
        end
      end
      // framing error: rearm only once the line has returned high
      R_WAIT:  if (rxd_s) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= R_IDLE;
      clk_cnt       <= '0;
      bit_idx       <= 3'd0;
      shreg         <= 8'h00;
      rx_byte       <= 8'h00;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_state      <= rx_next;
      rx_byte_valid <= stop_ok;
      frame_err     <= stop_bad;
      if (rx_state == R_IDLE || rx_state == R_WAIT || rx_next != rx_state || bit_tick)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == R_DATA && bit_tick) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (stop_ok) rx_byte <= shreg;
    end
  end

  // ---------------- inter-byte timeout ----------------
  typedef enum logic [1:0] {P_IDLE, P_CMD, P_PAYLOAD, P_CHECK} p_state_t;
  p_state_t p_state, p_next;
  logic [GW-1:0] gap_cnt;
  logic          gap_hit;

  assign gap_hit = (gap_cnt == GW'(GAP_LIMIT));

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)
      gap_cnt <= '0;
    else if (rx_state != R_IDLE || p_state == P_IDLE || rx_byte_valid || gap_hit)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + 1'b1;
  end

  // ---------------- frame parser ----------------
  logic [7:0]  cmd_q, chk_acc;
  logic [3:0]  pay_idx, pay_len, cmd_len;
  logic [71:0] pay_sr;   // shadow: newest payload byte in [7:0]
  logic        accept, reject;

  always_comb begin
    cmd_len = 4'd0;
    unique case (rx_byte)
      8'h01:   cmd_len = 4'd9;
      8'h02:   cmd_len = 4'd3;
      8'h03:   cmd_len = 4'd1;
      default: cmd_len = 4'd0;
    endcase
  end

  always_comb begin
    p_next = p_state;
    accept = 1'b0;
    reject = 1'b0;
    if (frame_err) begin
      p_next = P_IDLE;
      reject = 1'b1;
    end else if (gap_hit) begin
      p_next = P_IDLE;
      reject = 1'b1;
    end else if (rx_byte_valid) begin
      unique case (p_state)
        P_IDLE: if (rx_byte == 8'hA5) p_next = P_CMD;
        P_CMD: begin
          if (cmd_len != 4'd0) p_next = P_PAYLOAD;
          else begin
            p_next = P_IDLE;
            reject = 1'b1;
          end
        end
        P_PAYLOAD: if (pay_idx == pay_len - 4'd1) p_next = P_CHECK;
        P_CHECK: begin
          p_next = P_IDLE;
          if (rx_byte == chk_acc && !(cmd_q == 8'h01 && pay_sr[71:64] > 8'd15))
            accept = 1'b1;
          else
            reject = 1'b1;
        end
        default: p_next = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      p_state   <= P_IDLE;
      cmd_q     <= 8'h00;
      chk_acc   <= 8'h00;
      pay_idx   <= 4'd0;
      pay_len   <= 4'd0;
      pay_sr    <= '0;
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;
      wbl_we    <= 1'b0;
      addr_we   <= 1'b0;
      io_start  <= 1'b0;
      wbl_chip  <= 4'd0;
      wbl_data  <= 64'd0;
      wwl_add   <= 6'd0;
      rwl_add   <= 6'd0;
      demux_add <= 2'd0;
      io_model  <= 2'd0;
    end else begin
      p_state  <= p_next;
      cmd_ok   <= accept;
      cmd_err  <= reject;
      wbl_we   <= accept && cmd_q == 8'h01;
      addr_we  <= accept && cmd_q == 8'h02;
      io_start <= accept && cmd_q == 8'h03;
      if (rx_byte_valid && p_state == P_CMD) begin
        cmd_q   <= rx_byte;
        chk_acc <= rx_byte;
        pay_idx <= 4'd0;
        pay_len <= cmd_len;
      end
      if (rx_byte_valid && p_state == P_PAYLOAD) begin
        pay_sr  <= {pay_sr[63:0], rx_byte};
        chk_acc <= chk_acc ^ rx_byte;
        pay_idx <= pay_idx + 4'd1;
      end
      if (accept) begin
        unique case (cmd_q)
          8'h01: begin
            wbl_chip <= pay_sr[67:64];
            wbl_data <= pay_sr[63:0];
          end
          8'h02: begin
            wwl_add   <= pay_sr[21:16];
            rwl_add   <= pay_sr[13:8];
            demux_add <= pay_sr[1:0];
          end
          8'h03:   io_model <= pay_sr[1:0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: serial stimulus pushes expected bytes and
// command outcomes into queues; a negedge monitor pops and compares on pulses.
// Ports: drives clk_100m, rst_n, uart_rxd; observes every DUT output.
module tb_uart_cmd_rx;
  localparam int CPB = 32;
  localparam int GAP = 16;

  logic        clk_100m = 1'b0;
  logic        rst_n    = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        wbl_we;
  logic [3:0]  wbl_chip;
  logic [63:0] wbl_data;
  logic        addr_we;
  logic [5:0]  wwl_add;
  logic [5:0]  rwl_add;
  logic [1:0]  demux_add;
  logic        io_start;
  logic [1:0]  io_model;
  logic        cmd_ok;
  logic        cmd_err;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .uart_rxd(uart_rxd),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
    .wbl_we(wbl_we), .wbl_chip(wbl_chip), .wbl_data(wbl_data),
    .addr_we(addr_we), .wwl_add(wwl_add), .rwl_add(rwl_add), .demux_add(demux_add),
    .io_start(io_start), .io_model(io_model), .cmd_ok(cmd_ok), .cmd_err(cmd_err)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct {
    logic        ok;
    logic [2:0]  strb;   // {wbl_we, addr_we, io_start}
    logic [83:0] outs;   // {chip, data, wwl, rwl, demux, model}
  } ev_t;

  logic [7:0] byte_q[$];
  ev_t        ev_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  // reference copy of the visible command outputs
  logic [3:0]  m_chip  = '0;
  logic [63:0] m_data  = '0;
  logic [5:0]  m_wwl   = '0;
  logic [5:0]  m_rwl   = '0;
  logic [1:0]  m_dmx   = '0;
  logic [1:0]  m_mdl   = '0;

  function automatic logic [83:0] model_outs();
    return {m_chip, m_data, m_wwl, m_rwl, m_dmx, m_mdl};
  endfunction

  function automatic logic [83:0] dut_outs();
    return {wbl_chip, wbl_data, wwl_add, rwl_add, demux_add, io_model};
  endfunction

  task automatic push_ev(input logic ok, input logic [2:0] strb);
    ev_t e;
    e.ok   = ok;
    e.strb = strb;
    e.outs = model_outs();
    ev_q.push_back(e);
  endtask

  task automatic exp_err();
    push_ev(1'b0, 3'b000);
  endtask

  task automatic exp_wbl(input logic [3:0] chip, input logic [63:0] data);
    m_chip = chip;
    m_data = data;
    push_ev(1'b1, 3'b100);
  endtask

  task automatic exp_addr(input logic [5:0] w, input logic [5:0] r, input logic [1:0] d);
    m_wwl = w;
    m_rwl = r;
    m_dmx = d;
    push_ev(1'b1, 3'b010);
  endtask

  task automatic exp_io(input logic [1:0] m);
    m_mdl = m;
    push_ev(1'b1, 3'b001);
  endtask

  // one 8N1 character, LSB first; called on a negedge, returns on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) byte_q.push_back(b);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk_100m);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk_100m);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk_100m);
    uart_rxd = 1'b1;
  endtask

  // A5, cmd, plen payload bytes (first byte in the top of the used range),
  // then XOR checksum of cmd and payload, optionally corrupted
  task automatic send_frame(input logic [7:0] cmd, input logic [71:0] pay,
                            input int plen, input logic [7:0] corrupt);
    logic [7:0] chk;
    logic [7:0] b;
    chk = cmd;
    send_byte(8'hA5, 1'b1);
    send_byte(cmd, 1'b1);
    for (int k = 0; k < plen; k++) begin
      b   = pay[8*(plen-1-k) +: 8];
      chk = chk ^ b;
      send_byte(b, 1'b1);
    end
    send_byte(chk ^ corrupt, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    repeat (n * CPB) @(negedge clk_100m);
  endtask

  // ---------------- monitor ----------------
  logic [7:0] mon_b;
  ev_t        mon_e;
  always @(negedge clk_100m) begin
    if (rst_n) begin
      if (rx_byte_valid) begin
        n_cmp++;
        if (byte_q.size() == 0) begin
          n_fail++;
          $display("FAIL byte_unexpected: got %h, required no byte", rx_byte);
        end else begin
          mon_b = byte_q.pop_front();
          if (rx_byte !== mon_b) begin
            n_fail++;
            $display("FAIL rx_byte: got %h, required %h", rx_byte, mon_b);
          end
        end
      end
      if (cmd_ok || cmd_err) begin
        n_cmp++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_unexpected: got ok=%b err=%b, required no outcome", cmd_ok, cmd_err);
        end else begin
          mon_e = ev_q.pop_front();
          if (cmd_ok !== mon_e.ok || cmd_err !== !mon_e.ok ||
              {wbl_we, addr_we, io_start} !== mon_e.strb) begin
            n_fail++;
            $display("FAIL cmd_pulses: got ok=%b err=%b strb=%b, required ok=%b err=%b strb=%b",
                     cmd_ok, cmd_err, {wbl_we, addr_we, io_start},
                     mon_e.ok, !mon_e.ok, mon_e.strb);
          end
          n_cmp++;
          if (dut_outs() !== mon_e.outs) begin
            n_fail++;
            $display("FAIL cmd_outputs: got %h, required %h", dut_outs(), mon_e.outs);
          end
        end
      end else if (wbl_we || addr_we || io_start) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_strobe: got strb=%b, required 000", {wbl_we, addr_we, io_start});
      end
    end
  end

  task automatic check_zero(input string name);
    n_cmp++;
    if ({rx_byte_valid, rx_byte, wbl_we, addr_we, io_start, cmd_ok, cmd_err} !== '0 ||
        dut_outs() !== '0) begin
      n_fail++;
      $display("FAIL %s: got pulses=%b byte=%h outs=%h, required all zero", name,
               {rx_byte_valid, wbl_we, addr_we, io_start, cmd_ok, cmd_err}, rx_byte, dut_outs());
    end
  endtask

  initial begin
    repeat (4) @(negedge clk_100m);
    check_zero("reset_state");
    rst_n = 1'b1;
    repeat (4) @(negedge clk_100m);
    check_zero("after_release");

    // WBL write
    exp_wbl(4'd3, 64'h1122334455667788);
    send_frame(8'h01, 72'h03_1122334455667788, 9, 8'h00);
    idle_bits(2);

    // address then IO, back to back with no idle between frames
    exp_addr(6'd5, 6'd42, 2'd3);
    exp_io(2'b01);
    send_frame(8'h02, {48'h0, 24'h05_2A_03}, 3, 8'h00);
    send_frame(8'h03, {64'h0, 8'h01}, 1, 8'h00);
    idle_bits(2);

    // bad checksum: outputs held
    exp_err();
    send_frame(8'h02, {48'h0, 24'h05_2A_03}, 3, 8'h01);
    idle_bits(2);

    // stray byte dropped silently, unknown command rejected, then good frame
    send_byte(8'h7E, 1'b1);
    exp_err();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h09, 1'b1);
    exp_io(2'b10);
    send_frame(8'h03, {64'h0, 8'h02}, 1, 8'h00);
    idle_bits(2);

    // chip index 16 rejected
    exp_err();
    send_frame(8'h01, 72'h10_0102030405060708, 9, 8'h00);
    idle_bits(2);

    // framing error on a payload byte aborts the frame
    exp_err();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h2A, 1'b0);
    idle_bits(2);
    // upper payload bits ignored
    exp_addr(6'h07, 6'h01, 2'd2);
    send_frame(8'h02, {48'h0, 24'hC7_81_FE}, 3, 8'h00);
    idle_bits(2);

    // 100 ns low glitch on the idle line
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk_100m);
    idle_bits(3);

    // inter-byte timeout mid-frame
    exp_err();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    idle_bits(20);

    // reset asserted in the middle of a payload byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h03, 1'b1);
    uart_rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk_100m);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    uart_rxd = 1'b1;
    m_chip = '0; m_data = '0; m_wwl = '0; m_rwl = '0; m_dmx = '0; m_mdl = '0;
    repeat (5) @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_100m);
    check_zero("post_reset");

    // first frame after reset, highest legal chip index
    exp_wbl(4'd15, 64'hDEADBEEF01234567);
    send_frame(8'h01, 72'h0F_DEADBEEF01234567, 9, 8'h00);
    idle_bits(2);

    for (int i = 0; i < 4000 && (byte_q.size() != 0 || ev_q.size() != 0); i++)
      @(negedge clk_100m);
    n_cmp++;
    if (byte_q.size() != 0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d bytes and %0d outcomes pending, required 0 and 0",
               byte_q.size(), ev_q.size());
    end
    n_cmp++;
    if (dut_outs() !== model_outs()) begin
      n_fail++;
      $display("FAIL final_outputs: got %h, required %h", dut_outs(), model_outs());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
